// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 64;

  localparam logic [XLEN-1:0] DefaultResetPc   = 64'h0;
  // addi x0, x0, 0
  localparam logic [31:0]     DefaultNopInstr  = 32'h0000_0013;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StKill
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry PC/instruction buffer that parks a response while decode is stalled.
module fetch_skid #(
  parameter int unsigned XLEN = fetch_pkg::XLEN
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  // Next-state: clear wins over load, load wins over drain.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  // Buffer storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns PC_F, drives a single-outstanding imem port, handles
// Execute redirects and delivers instructions to the IF/ID boundary.
module fetch_ctrl #(
  parameter int unsigned      XLEN      = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC  = fetch_pkg::DefaultResetPc,
  parameter logic [31:0]      NOP_INSTR = fetch_pkg::DefaultNopInstr
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrc_E,
  input  logic [XLEN-1:0] PCTarget_E,
  input  logic            Stall_D,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] PC_D,
  output logic [31:0]     Instr_D,
  output logic            Valid_D
);

  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_infl_q, pc_infl_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic            out_valid_q, out_valid_d;

  logic            slot_free;
  logic            deliver_mem, deliver_skid;
  logic            skid_load, skid_drain, skid_clear;
  logic            skid_valid;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_instr;
  logic [XLEN-1:0] redirect_pc;

  // Low two target bits are forced to zero so fetch stays word aligned.
  assign redirect_pc = PCTarget_E & ~XLEN'(3);

  // The output register can take a new instruction if empty or being consumed.
  assign slot_free = !out_valid_q || !Stall_D;

  // Controller next-state, PC update and skid control.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    pc_infl_d    = pc_infl_q;
    deliver_mem  = 1'b0;
    deliver_skid = 1'b0;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;

    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_gnt) begin
          pc_infl_d = pc_f_q;
          pc_f_d    = pc_f_q + XLEN'(4);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (slot_free) begin
            deliver_mem = 1'b1;
            state_d     = StReq;
          end else begin
            skid_load = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (!Stall_D) begin
          deliver_skid = 1'b1;
          skid_drain   = 1'b1;
          state_d      = StReq;
        end
      end
      StKill: begin
        // Stale response is swallowed; the next request uses the new PC_F.
        if (imem_rvalid) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    // A redirect overrides any delivery and buffered data.
    if (PCSrc_E) begin
      pc_f_d       = redirect_pc;
      deliver_mem  = 1'b0;
      deliver_skid = 1'b0;
      skid_load    = 1'b0;
      skid_drain   = 1'b0;
      case (state_q)
        // A granted request is already in flight for the old address.
        StReq:   state_d = imem_gnt ? StKill : StReq;
        StWait:  state_d = imem_rvalid ? StReq : StKill;
        StHold:  state_d = StReq;
        default: state_d = state_d;
      endcase
    end
  end

  assign skid_clear = PCSrc_E;

  // IF/ID output slot next-state.
  always_comb begin
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_valid_d = out_valid_q;
    if (PCSrc_E) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end else if (deliver_mem) begin
      out_pc_d    = pc_infl_q;
      out_instr_d = imem_rdata;
      out_valid_d = 1'b1;
    end else if (deliver_skid) begin
      out_pc_d    = skid_pc;
      out_instr_d = skid_instr;
      out_valid_d = skid_valid;
    end else if (!Stall_D) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
    end
  end

  // State, PC and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_f_q      <= RESET_PC;
      pc_infl_q   <= RESET_PC;
      out_pc_q    <= '0;
      out_instr_q <= NOP_INSTR;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      pc_infl_q   <= pc_infl_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      out_valid_q <= out_valid_d;
    end
  end

  fetch_skid #(
    .XLEN(XLEN)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .pc_i    (pc_infl_q),
    .instr_i (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .instr_o (skid_instr)
  );

  assign imem_req  = (state_q == StReq);
  assign imem_addr = pc_f_q;
  assign PC_D      = out_pc_q;
  assign Instr_D   = out_instr_q;
  assign Valid_D   = out_valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: configurable memory responder, stream-level reference
// model (expected next delivered PC) and directed scenarios.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [63:0] RstPc = 64'h0;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrc_E = 1'b0;
  logic [63:0] PCTarget_E = '0;
  logic        Stall_D = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] PC_D;
  logic [31:0] Instr_D;
  logic        Valid_D;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gnt_delay = 0;
  int rv_delay  = 1;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrc_E     (PCSrc_E),
    .PCTarget_E  (PCTarget_E),
    .Stall_D     (Stall_D),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PC_D        (PC_D),
    .Instr_D     (Instr_D),
    .Valid_D     (Valid_D)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Instruction memory contents: addi x_i, x0, i with i = word index + 1,
  // plus one marker word at 0x50.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] i;
    if (a == 64'h50) return 32'h6464_6464;
    i = {22'b0, a[11:2]} + 32'd1;
    return (i << 20) | ((i & 32'h1f) << 7) | 32'h13;
  endfunction

  // Memory responder: grant after gnt_delay cycles of req, respond rv_delay
  // cycles after the grant.
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  int          req_cnt = 0;
  logic [63:0] pend_addr = '0;
  initial forever begin
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (!rst) begin
      pend    = 1'b0;
      req_cnt = 0;
    end else if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end
    end else if (imem_req) begin
      if (req_cnt >= gnt_delay) begin
        imem_gnt  = 1'b1;
        pend      = 1'b1;
        pend_cnt  = rv_delay;
        pend_addr = imem_addr;
        req_cnt   = 0;
      end else begin
        req_cnt++;
      end
    end else begin
      req_cnt = 0;
    end
  end

  // Reference model: deliveries form the sequential stream starting at the
  // last redirect target (or reset PC); checked after every clock edge.
  logic [63:0] exp_pc = RstPc;
  logic        prev_valid = 1'b0;
  logic        prev_req = 1'b0;
  logic [63:0] prev_pc = '0;
  logic [63:0] prev_addr = '0;
  logic [31:0] prev_instr = '0;
  int          deliv_cyc[$];
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      if (PCSrc_E) begin
        check("redirect_valid", 64'(Valid_D), 64'd0);
        check("redirect_instr", 64'(Instr_D), 64'(Nop));
        exp_pc = PCTarget_E & ~64'd3;
      end else if (prev_valid && Stall_D) begin
        check("hold_valid", 64'(Valid_D), 64'd1);
        check("hold_pc", PC_D, prev_pc);
        check("hold_instr", 64'(Instr_D), 64'(prev_instr));
      end else if (Valid_D) begin
        check("deliver_pc", PC_D, exp_pc);
        check("deliver_instr", 64'(Instr_D), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        deliv_cyc.push_back(cyc);
      end else begin
        check("idle_instr", 64'(Instr_D), 64'(Nop));
      end
      if (prev_req && !imem_gnt && !PCSrc_E) begin
        check("addr_stable_req", 64'(imem_req), 64'd1);
        check("addr_stable", imem_addr, prev_addr);
      end
    end else begin
      exp_pc = RstPc;
    end
    prev_valid = Valid_D;
    prev_req   = imem_req && rst;
    prev_pc    = PC_D;
    prev_addr  = imem_addr;
    prev_instr = Instr_D;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int gd, input int rd);
    rst     = 1'b0;
    PCSrc_E = 1'b0;
    Stall_D = 1'b0;
    tick();
    tick();
    gnt_delay = gd;
    rv_delay  = rd;
    rst       = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!Valid_D && k < 100) begin
      tick();
      k++;
    end
    check({nm, "_seen"}, 64'(Valid_D), 64'd1);
  endtask

  task automatic wait_req_addr(input logic [63:0] a, input string nm);
    int k = 0;
    while (!(imem_req && imem_addr == a) && k < 100) begin
      tick();
      k++;
    end
    check({nm, "_req"}, 64'(imem_req), 64'd1);
    check({nm, "_addr"}, imem_addr, a);
  endtask

  task automatic wait_inflight(input string nm);
    int k = 0;
    while (!(pend && !imem_req) && k < 100) begin
      tick();
      k++;
    end
    check({nm, "_inflight"}, 64'(pend), 64'd1);
  endtask

  initial begin
    int base;
    tick();
    tick();
    // Reset values.
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, 64'h0);
    check("rst_pc_d", PC_D, 64'h0);
    check("rst_instr", 64'(Instr_D), 64'h13);
    check("rst_valid", 64'(Valid_D), 64'd0);

    // Back-to-back memory: one delivery every two cycles.
    do_reset(0, 1);
    base = deliv_cyc.size();
    wait_valid("t1_d0");
    check("t1_pc0", PC_D, 64'h0);
    check("t1_in0", 64'(Instr_D), 64'h0010_0093);
    tick();
    wait_valid("t1_d1");
    check("t1_pc1", PC_D, 64'h4);
    check("t1_in1", 64'(Instr_D), 64'h0020_0113);
    tick();
    wait_valid("t1_d2");
    check("t1_pc2", PC_D, 64'h8);
    check("t1_in2", 64'(Instr_D), 64'h0030_0193);
    check("t1_gap01", 64'(deliv_cyc[base+1] - deliv_cyc[base]), 64'd2);
    check("t1_gap12", 64'(deliv_cyc[base+2] - deliv_cyc[base+1]), 64'd2);

    // Slow grant: address must hold while waiting.
    do_reset(3, 2);
    wait_valid("t2_d0");
    check("t2_pc0", PC_D, 64'h0);
    wait_req_addr(64'h4, "t2_req4");
    for (int i = 0; i < 3; i++) begin
      check("t2_hold_req", 64'(imem_req), 64'd1);
      check("t2_hold_addr", imem_addr, 64'h4);
      tick();
    end
    wait_valid("t2_d1");
    check("t2_pc1", PC_D, 64'h4);

    // Decode stall from first delivery for four cycles.
    do_reset(0, 1);
    wait_valid("t3_d0");
    Stall_D = 1'b1;
    tick();
    tick();
    tick();
    check("t3_hold_req", 64'(imem_req), 64'd0);
    check("t3_hold_valid", 64'(Valid_D), 64'd1);
    check("t3_hold_pc", PC_D, 64'h0);
    check("t3_skid_full", 64'(dut.u_skid.valid_o), 64'd1);
    tick();
    Stall_D = 1'b0;
    tick();
    check("t3_rel_valid", 64'(Valid_D), 64'd1);
    check("t3_rel_pc", PC_D, 64'h4);
    check("t3_next_req", 64'(imem_req), 64'd1);
    check("t3_next_addr", imem_addr, 64'h8);
    // Fill the skid again, then redirect to a misaligned target.
    Stall_D = 1'b1;
    tick();
    tick();
    check("t3b_skid_full", 64'(dut.u_skid.valid_o), 64'd1);
    PCSrc_E    = 1'b1;
    PCTarget_E = 64'h53;
    tick();
    PCSrc_E = 1'b0;
    Stall_D = 1'b0;
    check("t3b_valid", 64'(Valid_D), 64'd0);
    check("t3b_skid_empty", 64'(dut.u_skid.valid_o), 64'd0);
    check("t3b_req", 64'(imem_req), 64'd1);
    check("t3b_addr", imem_addr, 64'h50);
    wait_valid("t3b_d");
    check("t3b_pc", PC_D, 64'h50);
    check("t3b_instr", 64'(Instr_D), 64'h6464_6464);

    // Redirect while waiting for a response.
    do_reset(0, 3);
    wait_inflight("t4");
    PCSrc_E    = 1'b1;
    PCTarget_E = 64'h50;
    tick();
    PCSrc_E = 1'b0;
    check("t4_state_kill", 64'(dut.state_q), 64'(StKill));
    check("t4_valid", 64'(Valid_D), 64'd0);
    wait_req_addr(64'h50, "t4_req50");
    wait_valid("t4_d");
    check("t4_pc", PC_D, 64'h50);
    check("t4_instr", 64'(Instr_D), 64'h6464_6464);

    // Reset mid-WAIT.
    do_reset(0, 3);
    wait_valid("t5_d0");
    tick();
    wait_valid("t5_d1");
    check("t5_pc1", PC_D, 64'h4);
    tick();
    wait_inflight("t5");
    rst = 1'b0;
    #1;
    check("t5_rst_pc", PC_D, 64'h0);
    check("t5_rst_valid", 64'(Valid_D), 64'd0);
    check("t5_rst_instr", 64'(Instr_D), 64'h13);
    check("t5_rst_req", 64'(imem_req), 64'd0);
    check("t5_rst_addr", imem_addr, 64'h0);
    check("t5_rst_state", 64'(dut.state_q), 64'(StIdle));
    tick();
    rst = 1'b1;
    wait_req_addr(64'h0, "t5_first");
    wait_valid("t5_d2");
    check("t5_pc_again", PC_D, 64'h0);

    // PC wrap-around.
    do_reset(0, 1);
    tick();
    PCSrc_E    = 1'b1;
    PCTarget_E = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    PCSrc_E = 1'b0;
    wait_req_addr(64'hFFFF_FFFF_FFFF_FFFC, "t6_top");
    tick();
    wait_req_addr(64'h0, "t6_wrap");
    wait_valid("t6_d");
    check("t6_pc_top", PC_D, 64'hFFFF_FFFF_FFFF_FFFC);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
